// File: rtl/intersection_sequencer.sv
// Two-road traffic-light phase sequencer: prescaled tick, per-phase tick timer, 8-phase ring
// with request-gated left-turn phases. Optional flashing mode when FLASH_MODE_EN is defined.
module intersection_sequencer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned GREEN_T  = 10,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned ALLRED_T = 2,
  parameter int unsigned LEFT_T   = 5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       hold,
`ifdef FLASH_MODE_EN
  input  logic       flash,
`endif
  input  logic [1:0] left_req,
  output logic [2:0] phase,
  output logic       tick,
  output logic       phase_adv,
  output logic [1:0] greenOut,
  output logic [1:0] redOut,
  output logic [1:0] yellowOut,
  output logic [1:0] leftOut
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StNsGreen, StNsYellow, StAllRedA, StEwLeft,
    StEwGreen, StEwYellow, StAllRedB, StNsLeft
  } phase_e;

  phase_e          phase_q, phase_d, next_phase;
  logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]      timer_q, timer_d, dur_last;
  logic [1:0]      pending_q, pending_d;

`ifdef FLASH_MODE_EN
  logic flash_q, flash_on_q, flash_on_d;
`endif

  assign phase = phase_q;

  always_comb begin
    dur_last = 8'(GREEN_T - 1);
    unique case (phase_q[1:0])
      2'd0: dur_last = 8'(GREEN_T - 1);
      2'd1: dur_last = 8'(YELLOW_T - 1);
      2'd2: dur_last = 8'(ALLRED_T - 1);
      2'd3: dur_last = 8'(LEFT_T - 1);
      default: dur_last = 8'(GREEN_T - 1);
    endcase
  end

  // Left phases are entered only with a request latched before the all-red phase ends.
  always_comb begin
    next_phase = phase_e'(phase_q + 3'd1);
    if (phase_q == StAllRedA) begin
      next_phase = pending_q[1] ? StEwLeft : StEwGreen;
    end else if (phase_q == StAllRedB) begin
      next_phase = pending_q[0] ? StNsLeft : StNsGreen;
    end
  end

  always_comb begin
    tick       = (tick_cnt_q == CntMax);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    phase_adv  = 1'b0;
    phase_d    = phase_q;
    timer_d    = timer_q;

    if (tick && !hold) begin
      if (timer_q == dur_last) phase_adv = 1'b1;
      else                     timer_d   = timer_q + 8'd1;
    end
    if (phase_adv) begin
      phase_d = next_phase;
      timer_d = '0;
    end

    // A road's request is dropped from its entry cycle through its whole left phase.
    pending_d = pending_q | left_req;
    if (phase_q == StEwLeft || (phase_adv && next_phase == StEwLeft)) pending_d[1] = 1'b0;
    if (phase_q == StNsLeft || (phase_adv && next_phase == StNsLeft)) pending_d[0] = 1'b0;

`ifdef FLASH_MODE_EN
    flash_on_d = 1'b0;
    if (flash) begin
      phase_adv  = 1'b0;
      phase_d    = StAllRedA;
      timer_d    = '0;
      pending_d  = '0;
      flash_on_d = !flash_q ? 1'b0 : (tick ? !flash_on_q : flash_on_q);
    end
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      phase_q    <= StAllRedA;
      tick_cnt_q <= '0;
      timer_q    <= '0;
      pending_q  <= '0;
`ifdef FLASH_MODE_EN
      flash_q    <= 1'b0;
      flash_on_q <= 1'b0;
`endif
    end else begin
      phase_q    <= phase_d;
      tick_cnt_q <= tick_cnt_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
`ifdef FLASH_MODE_EN
      flash_q    <= flash;
      flash_on_q <= flash_on_d;
`endif
    end
  end

  // Lamp decode: bit0 = N/S, bit1 = E/W.
  always_comb begin
    greenOut  = 2'b00;
    redOut    = 2'b00;
    yellowOut = 2'b00;
    leftOut   = 2'b00;
    unique case (phase_q)
      StNsGreen:  begin greenOut  = 2'b01; redOut = 2'b10; end
      StNsYellow: begin yellowOut = 2'b01; redOut = 2'b10; end
      StAllRedA:  redOut = 2'b11;
      StEwLeft:   begin leftOut   = 2'b10; redOut = 2'b11; end
      StEwGreen:  begin greenOut  = 2'b10; redOut = 2'b01; end
      StEwYellow: begin yellowOut = 2'b10; redOut = 2'b01; end
      StAllRedB:  redOut = 2'b11;
      StNsLeft:   begin leftOut   = 2'b01; redOut = 2'b11; end
      default:    redOut = 2'b11;
    endcase
`ifdef FLASH_MODE_EN
    if (flash) begin
      greenOut  = 2'b00;
      leftOut   = 2'b00;
      yellowOut = flash_on_q ? 2'b01 : 2'b00;
      redOut    = flash_on_q ? 2'b10 : 2'b00;
    end
`endif
  end

endmodule
